dff_demux_deser: RTL and testbench
==================================

# dff_demux_deser

Receive-side counterpart of the 2:1 select-and-register flop. It takes one serial bit stream and steers each accepted bit, by `sel`, into one of two independent lane deserialisers. Each lane assembles WIDTH-bit words and presents them on a registered output with a valid/ack handshake. The block sits between a single serial source and two parallel consumers, and applies per-lane backpressure to the source through `din_ready`.

## Interface
- WIDTH, 8, bits per assembled word per lane; legal range 2..32.

- clk  input  1  rising-edge clock, single domain
- rst  input  1  asynchronous, active-high reset
- din  input  1  serial data bit
- din_valid  input  1  `din` is valid this cycle
- sel  input  1  lane select: 0 = lane 0, 1 = lane 1; X/Z is treated as 0
- din_ready  output  1  selected lane can accept a bit this cycle (combinational from `sel` and lane state)
- q0  output  WIDTH  lane 0 word, registered
- q0_valid  output  1  `q0` holds an unconsumed word
- q0_ack  input  1  consumer takes `q0`; only meaningful while `q0_valid`=1
- q1, q1_valid, q1_ack  same as lane 0, for lane 1

## Operation
- **Per-lane state.** Each lane holds:
  - shift register `sr[WIDTH-1:0]`
  - bit count `cnt`, range 0..WIDTH
  - output register `q`
  - flag `q_valid`
- **Lane readiness.** `lane_ready = (cnt < WIDTH)`; `din_ready = sel ? lane1_ready : lane0_ready`.
- **Accept.** A bit is accepted when `din_valid & din_ready`, and goes only to the selected lane. The other lane is unaffected.
- **Shift order.** MSB-first: `sr <= {sr[WIDTH-2:0], din}`, `cnt <= cnt+1`. The first accepted bit ends up in `q[WIDTH-1]`.
- **Word complete.** This is the accept that makes `cnt` reach WIDTH.
  - If `q_valid`=0, or `q_ack`=1 in the same cycle: load the completed word (including the new bit) into `q`, set `q_valid`=1, set `cnt`=0.
  - Otherwise: hold the word in `sr`, set `cnt`=WIDTH (lane full, not ready).
- **Full lane drain.** A full lane (`cnt`=WIDTH) loads `sr` into `q` and sets `cnt`=0 on the first cycle where `q_valid`=0 or `q_ack`=1. `q_valid` stays 1.
- **Ack.**
  - `q_ack`=1 with `q_valid`=1 and no load in the same cycle clears `q_valid`.
  - Ack and load in the same cycle leaves `q_valid`=1 with the new word.
  - `q_ack` with `q_valid`=0 is ignored.
- **Hold.** `q` holds its value until the next load; it is not cleared on ack.
- **Lane independence.** Lanes never interact except through the shared `din`/`sel`. Lane 1 is fully usable while lane 0 is full, and vice versa.
- **Reset.** `rst`=1 asynchronously clears `sr`, `cnt`, `q` (to 0) and `q_valid` (to 0) in both lanes. A partial word in progress is discarded. After reset, `din_ready`=1 for either `sel`.

## Timing
- **Output reset values.** `q0`=0, `q1`=0, `q0_valid`=0, `q1_valid`=0; `din_ready`=1.
- **Latency.** The WIDTH-th bit accepted at edge N gives `q` and `q_valid` updated right after edge N (0 extra cycles) when the output register is free.
- **Throughput.** One bit per cycle across both lanes. With ack held high, a lane delivers back-to-back words every WIDTH accepted bits with no bubble.
- **Backpressure.** When a lane is full, `din_ready` for that `sel` drops to 0 combinationally in the cycle after the completing edge. It rises again in the cycle after the edge on which the ack drains `sr`.
- **Ack to valid drop.** `q_valid` falls on the edge where ack is sampled, unless a held word loads on that same edge.
- **Reset timing.** Reset assertion takes effect immediately, without waiting for a clock edge. Deassertion is synchronised externally by the system. The first accept is possible on the first edge after release.
- **Input sampling.** `din_valid`, `din` and `sel` are sampled at the rising edge; a change of `sel` between edges re-evaluates `din_ready`.

## Test plan
- **Reset.** Assert `rst` mid-cycle while lane 0 has `cnt`=5 → immediately `q0`=`q1`=0, both valids 0, `din_ready`=1; then 8 new bits form a clean word with no stale bits.
- **Single lane word.** WIDTH=8, sel=0, bits 1,0,1,0,0,1,0,1 on consecutive cycles → after the 8th edge `q0`=8'hA5, `q0_valid`=1, `q1_valid`=0; ack one cycle → `q0_valid`=0, `q0` stays 8'hA5.
- **Interleaved lanes.** Alternate sel 0/1 per bit, feeding 8'hF0 to lane 0 and 8'h3C to lane 1 (16 cycles) → `q0`=8'hF0 and `q1`=8'h3C; each valid rises on the edge of that lane's 8th bit.
- **Backpressure.** sel=0, no ack, feed 8'h11 then 8'h22 → `q0`=8'h11, lane full, `din_ready`=0 with sel=0 and 1 with sel=1. Pulse `q0_ack` → next edge `q0`=8'h22, `q0_valid`=1, `din_ready`=1.
- **Same-cycle ack/complete.** `q0_valid`=1 (8'h55), 8th bit of 8'hAA accepted with `q0_ack`=1 on the same edge → `q0`=8'hAA, `q0_valid` never drops, no stall.
- **Ignored input.** `din_valid`=0 cycles and a spurious ack with `q_valid`=0 interleaved into a word → the word is unchanged and no valid appears early.

Source files
------------

// File: rtl/dff_demux_deser_if.sv
// Bundle of the serial-in / dual-lane parallel-out signals for dff_demux_deser.
// master = serial source plus both consumers, slave = the deserialiser itself.
interface dff_demux_deser_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             din_valid;
  logic             sel;
  logic             din_ready;
  logic [WIDTH-1:0] q0;
  logic             q0_valid;
  logic             q0_ack;
  logic [WIDTH-1:0] q1;
  logic             q1_valid;
  logic             q1_ack;

  modport master (
    output din, din_valid, sel, q0_ack, q1_ack,
    input  din_ready, q0, q0_valid, q1, q1_valid
  );

  modport slave (
    input  din, din_valid, sel, q0_ack, q1_ack,
    output din_ready, q0, q0_valid, q1, q1_valid
  );
endinterface

// File: rtl/dff_demux_deser.sv
// Steers a serial bit stream by sel into two independent MSB-first lane
// deserialisers, each with a registered word output and valid/ack handshake.
module dff_demux_deser #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  dff_demux_deser_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q   [2];
  logic [WIDTH-1:0] sr_d   [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [WIDTH-1:0] q_q    [2];
  logic [WIDTH-1:0] q_d    [2];
  logic             qv_q   [2];
  logic             qv_d   [2];

  logic             sel_s;
  logic             ack_s      [2];
  logic             lane_sel_s [2];
  logic             ready_s    [2];
  logic             free_s     [2];
  logic             accept_s   [2];
  logic [WIDTH-1:0] shift_s    [2];

  // Lane selection: anything other than a clean 1 on sel picks lane 0.
  always_comb begin
    sel_s = 1'b0;
    if (bus.sel == 1'b1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    lane_sel_s[0] = ~sel_s;
    lane_sel_s[1] = sel_s;
    ack_s[0]      = bus.q0_ack;
    ack_s[1]      = bus.q1_ack;
  end

  // Per-lane next state: shift, complete, park a full word, drain and ack.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sr_d[i]     = sr_q[i];
      cnt_d[i]    = cnt_q[i];
      q_d[i]      = q_q[i];
      qv_d[i]     = qv_q[i];
      ready_s[i]  = (cnt_q[i] < CNT_FULL);
      free_s[i]   = ~qv_q[i] | ack_s[i];
      shift_s[i]  = {sr_q[i][WIDTH-2:0], bus.din};
      accept_s[i] = bus.din_valid & ready_s[i] & lane_sel_s[i];

      if (accept_s[i] && (cnt_q[i] == CNT_LAST)) begin
        sr_d[i] = shift_s[i];
        if (free_s[i]) begin
          q_d[i]   = shift_s[i];
          qv_d[i]  = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = CNT_FULL;
        end
      end else if (accept_s[i]) begin
        sr_d[i]  = shift_s[i];
        cnt_d[i] = cnt_q[i] + CW'(1);
        qv_d[i]  = qv_q[i] & ~ack_s[i];
      end else if ((cnt_q[i] == CNT_FULL) && free_s[i]) begin
        // A parked word moves out as soon as the output register frees up.
        q_d[i]   = sr_q[i];
        qv_d[i]  = 1'b1;
        cnt_d[i] = '0;
      end else begin
        qv_d[i]  = qv_q[i] & ~ack_s[i];
      end
    end
  end

  // Lane state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sr_q[i]  <= '0;
        cnt_q[i] <= '0;
        q_q[i]   <= '0;
        qv_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sr_q[i]  <= sr_d[i];
        cnt_q[i] <= cnt_d[i];
        q_q[i]   <= q_d[i];
        qv_q[i]  <= qv_d[i];
      end
    end
  end

  assign bus.din_ready = sel_s ? ready_s[1] : ready_s[0];
  assign bus.q0        = q_q[0];
  assign bus.q0_valid  = qv_q[0];
  assign bus.q1        = q_q[1];
  assign bus.q1_valid  = qv_q[1];

endmodule

// File: tb/tb_dff_demux_deser.sv
// Directed bench for dff_demux_deser (WIDTH=8): reset, single-lane word,
// interleaved lanes, backpressure, same-cycle ack/complete, ignored input.
module tb_dff_demux_deser;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  dff_demux_deser_if #(.WIDTH(8)) bus ();

  dff_demux_deser #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic b);
    bus.sel       = s;
    bus.din       = b;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  // Sends bits w[hi] down to w[lo] to lane s, MSB first.
  task automatic send_bits(input logic s, input logic [7:0] w, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) begin
      send(s, w[k]);
    end
  endtask

  initial begin
    logic [7:0] w0;
    logic [7:0] w1;
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sel       = 1'b0;
    bus.q0_ack    = 1'b0;
    bus.q1_ack    = 1'b0;
    #12;
    chk("rst_q0", {24'd0, bus.q0}, 32'h0);
    chk("rst_q1", {24'd0, bus.q1}, 32'h0);
    chk("rst_q0_valid", {31'd0, bus.q0_valid}, 32'h0);
    chk("rst_q1_valid", {31'd0, bus.q1_valid}, 32'h0);
    chk("rst_din_ready", {31'd0, bus.din_ready}, 32'h1);
    rst = 1'b0;
    tick();

    // Five bits into lane 0, then a mid-cycle reset discards them.
    w0 = 8'hFF;
    send_bits(1'b0, w0, 7, 3);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_q0_valid", {31'd0, bus.q0_valid}, 32'h0);
    chk("midrst_q1_valid", {31'd0, bus.q1_valid}, 32'h0);
    chk("midrst_q0", {24'd0, bus.q0}, 32'h0);
    chk("midrst_rdy_sel0", {31'd0, bus.din_ready}, 32'h1);
    bus.sel = 1'b1;
    #0.1;
    chk("midrst_rdy_sel1", {31'd0, bus.din_ready}, 32'h1);
    #0.9;
    rst = 1'b0;
    tick();

    // Clean word 8'hA5 into lane 0.
    w0 = 8'hA5;
    send_bits(1'b0, w0, 7, 1);
    chk("a5_no_early_valid", {31'd0, bus.q0_valid}, 32'h0);
    send_bits(1'b0, w0, 0, 0);
    chk("a5_q0", {24'd0, bus.q0}, 32'hA5);
    chk("a5_q0_valid", {31'd0, bus.q0_valid}, 32'h1);
    chk("a5_q1_valid", {31'd0, bus.q1_valid}, 32'h0);
    bus.q0_ack = 1'b1;
    tick();
    bus.q0_ack = 1'b0;
    chk("a5_ack_valid", {31'd0, bus.q0_valid}, 32'h0);
    chk("a5_ack_hold", {24'd0, bus.q0}, 32'hA5);

    // Interleaved: lane 0 gets F0, lane 1 gets 3C.
    w0 = 8'hF0;
    w1 = 8'h3C;
    for (int k = 7; k >= 0; k--) begin
      send(1'b0, w0[k]);
      if (k == 0) begin
        chk("il_q0", {24'd0, bus.q0}, 32'hF0);
        chk("il_q0_valid", {31'd0, bus.q0_valid}, 32'h1);
        chk("il_q1_valid_pre", {31'd0, bus.q1_valid}, 32'h0);
      end
      send(1'b1, w1[k]);
    end
    chk("il_q1", {24'd0, bus.q1}, 32'h3C);
    chk("il_q1_valid", {31'd0, bus.q1_valid}, 32'h1);
    chk("il_q0_keep", {24'd0, bus.q0}, 32'hF0);
    bus.q0_ack = 1'b1;
    bus.q1_ack = 1'b1;
    tick();
    bus.q0_ack = 1'b0;
    bus.q1_ack = 1'b0;
    chk("il_ack_v0", {31'd0, bus.q0_valid}, 32'h0);
    chk("il_ack_v1", {31'd0, bus.q1_valid}, 32'h0);

    // Backpressure: 11 then 22 without ack fills lane 0.
    w0 = 8'h11;
    send_bits(1'b0, w0, 7, 0);
    w0 = 8'h22;
    send_bits(1'b0, w0, 7, 0);
    chk("bp_q0", {24'd0, bus.q0}, 32'h11);
    chk("bp_q0_valid", {31'd0, bus.q0_valid}, 32'h1);
    chk("bp_rdy_sel0", {31'd0, bus.din_ready}, 32'h0);
    bus.sel = 1'b1;
    #1;
    chk("bp_rdy_sel1", {31'd0, bus.din_ready}, 32'h1);
    bus.sel = 1'bx;
    #1;
    chk("bp_rdy_selx", {31'd0, bus.din_ready}, 32'h0);
    bus.sel = 1'b0;
    send(1'b0, 1'b1);
    chk("bp_still_full", {24'd0, bus.q0}, 32'h11);
    bus.q0_ack = 1'b1;
    tick();
    bus.q0_ack = 1'b0;
    chk("bp_drain_q0", {24'd0, bus.q0}, 32'h22);
    chk("bp_drain_valid", {31'd0, bus.q0_valid}, 32'h1);
    chk("bp_drain_rdy", {31'd0, bus.din_ready}, 32'h1);

    // Same-cycle ack and completion.
    bus.q0_ack = 1'b1;
    tick();
    bus.q0_ack = 1'b0;
    chk("sc_cleared", {31'd0, bus.q0_valid}, 32'h0);
    w0 = 8'h55;
    send_bits(1'b0, w0, 7, 0);
    chk("sc_q0_55", {24'd0, bus.q0}, 32'h55);
    w0 = 8'hAA;
    send_bits(1'b0, w0, 7, 1);
    chk("sc_hold_55", {24'd0, bus.q0}, 32'h55);
    chk("sc_valid_pre", {31'd0, bus.q0_valid}, 32'h1);
    bus.q0_ack = 1'b1;
    send(1'b0, w0[0]);
    bus.q0_ack = 1'b0;
    chk("sc_q0_aa", {24'd0, bus.q0}, 32'hAA);
    chk("sc_valid_kept", {31'd0, bus.q0_valid}, 32'h1);
    chk("sc_no_stall", {31'd0, bus.din_ready}, 32'h1);

    // Ignored input: idle cycles and spurious q1_ack inside a lane 1 word.
    w1 = 8'h96;
    for (int k = 7; k >= 0; k--) begin
      send(1'b1, w1[k]);
      if (k == 1) begin
        chk("ig_no_early_valid", {31'd0, bus.q1_valid}, 32'h0);
        chk("ig_q1_hold", {24'd0, bus.q1}, 32'h3C);
      end
      if (k > 0) begin
        bus.sel    = 1'b1;
        bus.din    = ~w1[k];
        bus.q1_ack = k[0];
        tick();
        bus.q1_ack = 1'b0;
      end
    end
    chk("ig_q1", {24'd0, bus.q1}, 32'h96);
    chk("ig_q1_valid", {31'd0, bus.q1_valid}, 32'h1);
    chk("ig_q0_untouched", {24'd0, bus.q0}, 32'hAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
